// File: rtl/udp_tx_packetizer.sv
// Packs return-FIFO bytes into UDP payload frames, flushed on full buffer or timeout.
// Define PKT_SEQ_HDR_EN to prefix every frame with a 16-bit big-endian sequence number.
module udp_tx_packetizer #(
    parameter int MAX_PAYLOAD   = 64,
    parameter int FLUSH_TIMEOUT = 1250
) (
    input  logic        clk_udp,
    input  logic        rst_udp,
    input  logic [7:0]  fifo_tdata,
    input  logic        fifo_tvalid,
    output logic        fifo_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [10:0] frame_len,
    output logic [15:0] frames_sent,
    output logic [2:0]  dbg_state
);

    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);
    localparam logic [15:0]   TO_LAST = 16'(FLUSH_TIMEOUT - 1);

    // Handshakes: a beat moves on either stream only in a cycle where valid && ready.
    // Once m_axis_tvalid is high, tdata/tlast hold until the beat is taken.
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        FILL         = 3'd1,
        SEND_HDR_HI  = 3'd2,
        SEND_HDR_LO  = 3'd3,
        SEND_PAYLOAD = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [AW-1:0]   idx, idx_next;
    logic [15:0]     timer, timer_next;
    logic [10:0]     frame_len_next;
    logic [15:0]     frames_sent_next;
    logic [7:0]      mem [MAX_PAYLOAD];
    logic [7:0]      rd_data;
    logic            accept;
    logic            flush;

`ifdef PKT_SEQ_HDR_EN
    localparam logic [10:0] HDR_LEN = 11'd2;
    logic [15:0] seq, seq_next;
`else
    localparam logic [10:0] HDR_LEN = 11'd0;
`endif

    assign dbg_state = state;

    always_comb begin
        fifo_tready = 1'b0;
        if (!rst_udp) begin
            fifo_tready = (state == IDLE) || ((state == FILL) && (count < MAX_CNT));
        end
        accept = fifo_tvalid && fifo_tready;
    end

    always_comb begin
        state_next       = state;
        count_next       = count;
        idx_next         = idx;
        timer_next       = timer;
        frame_len_next   = frame_len;
        frames_sent_next = frames_sent;
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = 8'h00;
        m_axis_tlast     = 1'b0;
        flush            = 1'b0;
`ifdef PKT_SEQ_HDR_EN
        seq_next         = seq;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    count_next = CW'(1);
                    timer_next = 16'd0;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    count_next = count + CW'(1);
                end
                timer_next = timer + 16'd1;
                // The byte taken in the exit cycle still belongs to this frame.
                flush = (count_next == MAX_CNT) || (timer == TO_LAST);
                if (flush) begin
                    frame_len_next = 11'(count_next) + HDR_LEN;
`ifdef PKT_SEQ_HDR_EN
                    state_next = SEND_HDR_HI;
`else
                    state_next = SEND_PAYLOAD;
`endif
                end
            end
`ifdef PKT_SEQ_HDR_EN
            SEND_HDR_HI: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = seq[15:8];
                if (m_axis_tready) begin
                    state_next = SEND_HDR_LO;
                end
            end
            SEND_HDR_LO: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = seq[7:0];
                if (m_axis_tready) begin
                    state_next = SEND_PAYLOAD;
                end
            end
`endif
            SEND_PAYLOAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = rd_data;
                m_axis_tlast  = (CW'(idx) == (count - CW'(1)));
                if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        idx_next         = '0;
                        count_next       = '0;
                        frames_sent_next = frames_sent + 16'd1;
`ifdef PKT_SEQ_HDR_EN
                        seq_next         = seq + 16'd1;
`endif
                        state_next       = IDLE;
                    end else begin
                        idx_next = idx + AW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The read port is addressed with next cycle's index, so rd_data always
    // holds buffer[idx] and the first payload beat needs no extra cycle.
    always_ff @(posedge clk_udp) begin
        if (accept) begin
            mem[count[AW-1:0]] <= fifo_tdata;
        end
        rd_data <= mem[idx_next];
    end

    always_ff @(posedge clk_udp) begin
        if (rst_udp) begin
            state       <= IDLE;
            count       <= '0;
            idx         <= '0;
            timer       <= 16'd0;
            frame_len   <= 11'd0;
            frames_sent <= 16'd0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            idx         <= idx_next;
            timer       <= timer_next;
            frame_len   <= frame_len_next;
            frames_sent <= frames_sent_next;
        end
    end

`ifdef PKT_SEQ_HDR_EN
    always_ff @(posedge clk_udp) begin
        if (rst_udp) begin
            seq <= 16'd0;
        end else begin
            seq <= seq_next;
        end
    end
`endif

endmodule
